// File: rtl/spr_ram_arbiter.sv
// rtl/spr_ram_arbiter.sv - shares one single-port RAM between an SPI command stream and a host port
// Optional ARB_FIXED_PRIO_EN: SPI always wins contention (default round-robin).
module spr_ram_arbiter #(
   parameter int MEMDEPTH  = 256,
   parameter int MEMWIDTH  = 8,
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [9:0]           spi_din,
   input  logic                 spi_rx_valid,
   output logic [MEMWIDTH-1:0]  spi_dout,
   output logic                 spi_tx_valid,
   output logic                 spi_ovf,
   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [ADDR_SIZE-1:0] host_addr,
   input  logic [MEMWIDTH-1:0]  host_wdata,
   output logic                 host_gnt,
   output logic [MEMWIDTH-1:0]  host_rdata,
   output logic                 host_rvalid,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [ADDR_SIZE-1:0] ram_addr,
   output logic [MEMWIDTH-1:0]  ram_wdata,
   input  logic [MEMWIDTH-1:0]  ram_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   generate
      if (MEMDEPTH > (1 << ADDR_SIZE)) begin : g_depth_check
         $error("spr_ram_arbiter: MEMDEPTH exceeds address space");
      end
   endgenerate

   state_t               state;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic                 pend;
   logic                 pend_rd;
   logic [ADDR_SIZE-1:0] pend_addr;
   logic [MEMWIDTH-1:0]  pend_data;
   logic                 cur_spi;
   logic                 cur_rd;
`ifndef ARB_FIXED_PRIO_EN
   logic                 last_spi;
`endif

   logic [1:0]           spi_cmd;
   logic                 spi_data_cmd;
   logic                 in_rd;
   logic [ADDR_SIZE-1:0] in_addr;
   logic [MEMWIDTH-1:0]  in_data;
   logic                 spi_req;
   logic                 op_rd;
   logic [ADDR_SIZE-1:0] op_addr;
   logic [MEMWIDTH-1:0]  op_data;
   logic                 pick_spi;
   logic                 spi_grant;
   logic                 host_grant;

   assign spi_cmd      = spi_din[9:8];
   assign spi_data_cmd = spi_rx_valid && spi_cmd[0];
   assign in_rd        = spi_cmd[1];
   assign in_addr      = spi_cmd[1] ? rd_addr : wr_addr;
   assign in_data      = MEMWIDTH'(spi_din[7:0]);

   // A data command arriving in IDLE competes immediately; a queued op always goes before it.
   always_comb begin
      spi_req  = pend || spi_data_cmd;
      op_rd    = pend ? pend_rd   : in_rd;
      op_addr  = pend ? pend_addr : in_addr;
      op_data  = pend ? pend_data : in_data;
`ifdef ARB_FIXED_PRIO_EN
      pick_spi = spi_req;
`else
      pick_spi = spi_req && (!host_req || !last_spi);
`endif
      spi_grant  = (state == IDLE) && pick_spi;
      host_grant = (state == IDLE) && host_req && !pick_spi;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wr_addr      <= '0;
         rd_addr      <= '0;
         pend         <= 1'b0;
         pend_rd      <= 1'b0;
         pend_addr    <= '0;
         pend_data    <= '0;
         cur_spi      <= 1'b0;
         cur_rd       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         last_spi     <= 1'b0;
`endif
         spi_dout     <= '0;
         spi_tx_valid <= 1'b0;
         spi_ovf      <= 1'b0;
         host_gnt     <= 1'b0;
         host_rdata   <= '0;
         host_rvalid  <= 1'b0;
         ram_en       <= 1'b0;
         ram_we       <= 1'b0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
      end else begin
         spi_tx_valid <= 1'b0;
         host_rvalid  <= 1'b0;
         host_gnt     <= 1'b0;
         ram_en       <= 1'b0;
         ram_we       <= 1'b0;

         if (spi_rx_valid && spi_cmd == 2'b00)
            wr_addr <= ADDR_SIZE'(spi_din[7:0]);
         if (spi_rx_valid && spi_cmd == 2'b10)
            rd_addr <= ADDR_SIZE'(spi_din[7:0]);

         // Buffer bookkeeping: a granted queued op frees the slot for a same-cycle arrival.
         if (spi_grant && pend)
            pend <= 1'b0;
         if (spi_data_cmd && !(spi_grant && !pend)) begin
            if (!pend || spi_grant) begin
               pend      <= 1'b1;
               pend_rd   <= in_rd;
               pend_addr <= in_addr;
               pend_data <= in_data;
            end else begin
               spi_ovf <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (spi_grant) begin
                  state    <= ISSUE;
                  ram_en   <= 1'b1;
                  ram_we   <= !op_rd;
                  ram_addr <= op_addr;
                  if (!op_rd)
                     ram_wdata <= op_data;
                  cur_spi  <= 1'b1;
                  cur_rd   <= op_rd;
`ifndef ARB_FIXED_PRIO_EN
                  last_spi <= 1'b1;
`endif
               end else if (host_grant) begin
                  state    <= ISSUE;
                  ram_en   <= 1'b1;
                  ram_we   <= host_we;
                  ram_addr <= host_addr;
                  if (host_we)
                     ram_wdata <= host_wdata;
                  host_gnt <= 1'b1;
                  cur_spi  <= 1'b0;
                  cur_rd   <= !host_we;
`ifndef ARB_FIXED_PRIO_EN
                  last_spi <= 1'b0;
`endif
               end
            end
            ISSUE: begin
               state <= cur_rd ? WAIT : IDLE;
            end
            WAIT: begin
               state <= IDLE;
               if (cur_spi) begin
                  spi_dout     <= ram_rdata;
                  spi_tx_valid <= 1'b1;
               end else begin
                  host_rdata  <= ram_rdata;
                  host_rvalid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
